// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two aligned memory words for a byte-addressed
// load, then shifts, masks and sign/zero-extends the requested bytes into a result.
package controls;
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        LWU = 3'd5,
        LD  = 3'd6
    } mem_op;
endpackage

module load_align_unit #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  controls::mem_op       ld_op,
    input  logic [ADDR_W-1:0]     ld_addr,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_SIZE-1:0]  rsp_data,
    output logic                  rsp_split
);
    import controls::*;

    localparam int BYTES = WORD_SIZE / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t                 state, state_next;
    mem_op                  op_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [WORD_SIZE-1:0]   lo_q, hi_q, rsp_data_q;
    logic                   rsp_split_q;

    logic [OFF_W-1:0]       offset;
    logic [ADDR_W-1:0]      aligned;
    logic [3:0]             size;
    logic                   sgn, split, sign_bit;
    logic [WORD_SIZE-1:0]   src_lo, src_hi, word, mask, result;
    logic [2*WORD_SIZE-1:0] shifted;

    assign offset  = addr_q[OFF_W-1:0];
    assign aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Access size and signedness; LWU/LD only narrow or widen anything on 64-bit words.
    always_comb begin
        size = 4'(BYTES);
        sgn  = 1'b0;
        case (op_q)
            LB:      begin size = 4'd1; sgn = 1'b1; end
            LBU:     size = 4'd1;
            LH:      begin size = 4'd2; sgn = 1'b1; end
            LHU:     size = 4'd2;
            LW:      begin size = 4'd4; sgn = (WORD_SIZE == 64); end
            LWU:     if (WORD_SIZE == 64) size = 4'd4;
            default: ;
        endcase
    end

    assign split = (5'(offset) + 5'(size)) > 5'(BYTES);

    // The result is built from the word arriving this cycle so it can be registered on entry to RESP.
    always_comb begin
        src_lo  = (state == WAIT1) ? lo_q : mem_rdata;
        src_hi  = (state == WAIT1) ? mem_rdata : hi_q;
        shifted = {src_hi, src_lo} >> {offset, 3'b000};
        word    = shifted[WORD_SIZE-1:0];
        mask    = (size >= 4'(BYTES)) ? '1 : ((WORD_SIZE'(1) << {size, 3'b000}) - WORD_SIZE'(1));
        case (size)
            4'd1:    sign_bit = word[7];
            4'd2:    sign_bit = word[15];
            4'd4:    sign_bit = word[31];
            default: sign_bit = word[WORD_SIZE-1];
        endcase
        result  = (word & mask) | ((sgn && sign_bit) ? ~mask : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                ld_ready = !rst;
                if (ld_valid && !rst) state_next = REQ0;
            end
            REQ0: begin
                mem_req  = 1'b1;
                mem_addr = aligned;
                if (mem_gnt) state_next = WAIT0;
            end
            WAIT0: if (mem_rvalid) state_next = split ? REQ1 : RESP;
            REQ1: begin
                mem_req  = 1'b1;
                mem_addr = aligned + ADDR_W'(BYTES);
                if (mem_gnt) state_next = WAIT1;
            end
            WAIT1: if (mem_rvalid) state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= LB;
            addr_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            rsp_data_q  <= '0;
            rsp_split_q <= 1'b0;
        end else begin
            if (state == IDLE && ld_valid) begin
                op_q   <= ld_op;
                addr_q <= ld_addr;
            end
            if (state == WAIT0 && mem_rvalid) lo_q <= mem_rdata;
            if (state == WAIT1 && mem_rvalid) hi_q <= mem_rdata;
            if (mem_rvalid && ((state == WAIT0 && !split) || state == WAIT1)) begin
                rsp_data_q  <= result;
                rsp_split_q <= (state == WAIT1);
            end
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_split = rsp_split_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit at WORD_SIZE=32: the bench plays the memory side
// cycle by cycle and checks requests, latency, results, stalls and reset recovery.
module tb_load_align_unit;
    import controls::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready;
    mem_op       ld_op;
    logic [31:0] ld_addr;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        rsp_valid, rsp_ready, rsp_split;
    logic [31:0] rsp_data;

    int testsRun    = 0;
    int testsFailed = 0;

    load_align_unit #(.WORD_SIZE(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_op(ld_op), .ld_addr(ld_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_split(rsp_split)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete load with prompt grant/rvalid/rsp_ready, checking each state on the way.
    task automatic applyStimulus(input string name, input mem_op op, input logic [31:0] addr,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic splitExp, input logic [31:0] dataExp);
        checkOutput({name, " ld_ready idle"}, 32'(ld_ready), 32'd1);
        ld_valid = 1'b1; ld_op = op; ld_addr = addr;
        step();
        ld_valid = 1'b0;
        checkOutput({name, " req0 mem_req"}, 32'(mem_req), 32'd1);
        checkOutput({name, " req0 mem_addr"}, mem_addr, a0);
        checkOutput({name, " req0 ld_ready"}, 32'(ld_ready), 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checkOutput({name, " wait0 mem_req"}, 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = d0;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        if (splitExp) begin
            checkOutput({name, " req1 mem_req"}, 32'(mem_req), 32'd1);
            checkOutput({name, " req1 mem_addr"}, mem_addr, a1);
            checkOutput({name, " req1 rsp_valid"}, 32'(rsp_valid), 32'd0);
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = d1;
            step();
            mem_rvalid = 1'b0; mem_rdata = 32'h0;
        end
        checkOutput({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({name, " rsp_data"}, rsp_data, dataExp);
        checkOutput({name, " rsp_split"}, 32'(rsp_split), 32'(splitExp));
        checkOutput({name, " resp mem_req"}, 32'(mem_req), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        checkOutput({name, " ld_ready back"}, 32'(ld_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_op = LB; ld_addr = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; rsp_ready = 1'b0;
        step();
        step();
        checkOutput("reset ld_ready", 32'(ld_ready), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_data", rsp_data, 32'h0);
        checkOutput("reset rsp_split", 32'(rsp_split), 32'd0);
        rst = 1'b0;
        step();

        applyStimulus("lb_103", LB, 32'h103, 32'h100, 32'h80FF1234, 32'h0, 32'h0, 1'b0, 32'hFFFFFF80);
        applyStimulus("lhu_102", LHU, 32'h102, 32'h100, 32'hBEEF0000, 32'h0, 32'h0, 1'b0, 32'h0000BEEF);
        applyStimulus("lw_101", LW, 32'h101, 32'h100, 32'h44332211, 32'h104, 32'h88776655, 1'b1, 32'h55443322);
        applyStimulus("lh_wrap", LH, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h34000000, 32'h0, 32'h00000092, 1'b1, 32'hFFFF9234);
        applyStimulus("lbu_201", LBU, 32'h201, 32'h200, 32'h0000A500, 32'h0, 32'h0, 1'b0, 32'h000000A5);
        applyStimulus("lh_pos", LH, 32'h300, 32'h300, 32'h00017FFF, 32'h0, 32'h0, 1'b0, 32'h00007FFF);
        applyStimulus("lw_aligned", LW, 32'h400, 32'h400, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
        applyStimulus("bad_op", mem_op'(3'd7), 32'h502, 32'h500, 32'h22221111, 32'h504, 32'h44443333, 1'b1, 32'h33332222);
        applyStimulus("lhu_split", LHU, 32'h503, 32'h500, 32'hCC000000, 32'h504, 32'h000000DD, 1'b1, 32'h0000DDCC);
        applyStimulus("lwu_32", LWU, 32'h600, 32'h600, 32'h87654321, 32'h0, 32'h0, 1'b0, 32'h87654321);

        // Grant held off four cycles with a stray rvalid, then the response held three cycles.
        ld_valid = 1'b1; ld_op = LB; ld_addr = 32'h700;
        step();
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = (i == 1); mem_rdata = 32'h55555555;
            checkOutput("stall mem_req", 32'(mem_req), 32'd1);
            checkOutput("stall mem_addr", mem_addr, 32'h700);
            checkOutput("stall ld_ready", 32'(ld_ready), 32'd0);
            step();
        end
        mem_rvalid = 1'b0;
        checkOutput("stall still req0", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h000000FE;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h900;
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold rsp_data", rsp_data, 32'hFFFFFFFE);
            checkOutput("hold ld_ready", 32'(ld_ready), 32'd0);
            step();
        end
        ld_valid = 1'b0;
        checkOutput("hold rsp_split", 32'(rsp_split), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("stall rsp_valid drop", 32'(rsp_valid), 32'd0);
        checkOutput("stall no second load", 32'(mem_req), 32'd0);

        // Reset in WAIT1 followed by a late rvalid that must be ignored.
        ld_valid = 1'b1; ld_op = LW; ld_addr = 32'h801;
        step();
        ld_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        step();
        mem_rvalid = 1'b0;
        checkOutput("rst req1 mem_addr", mem_addr, 32'h804);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst ld_ready", 32'(ld_ready), 32'd0);
        checkOutput("midrst mem_req", 32'(mem_req), 32'd0);
        checkOutput("midrst mem_addr", mem_addr, 32'h0);
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst rsp_data", rsp_data, 32'h0);
        checkOutput("midrst rsp_split", 32'(rsp_split), 32'd0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("postrst ld_ready", 32'(ld_ready), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("stray rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("stray ld_ready", 32'(ld_ready), 32'd1);
            checkOutput("stray mem_req", 32'(mem_req), 32'd0);
            step();
        end
        applyStimulus("after_rst", LB, 32'h103, 32'h100, 32'h80FF1234, 32'h0, 32'h0, 1'b0, 32'hFFFFFF80);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
